// File: rtl/fp_product_accumulator.sv
// fp_product_accumulator
// Multi-cycle single-precision accumulator placed behind the float multiplier.
// Each accepted product is added into a running IEEE-754 sum. The datapath
// walks IDLE -> ALIGN -> ADD -> NORM (one left shift per cycle) -> PACK.
// Rounding is toward zero, and denormals are flushed to zero. Overflow
// saturates the sum to +/-inf and latches it.
module fp_product_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_exception,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic [31:0]      acc_out,
  output logic             sum_valid,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             exc_flag,
  output logic             ovf_flag,
  output logic             uf_flag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  // Product captured at the accepting edge.
  logic [31:0] in_data_r;
  logic        in_exc_r;
  logic        in_ovf_r;
  logic        in_uf_r;

  // Aligned operands. X always has the larger (or equal) exponent.
  logic        x_sign_r;
  logic        y_sign_r;
  logic [7:0]  x_exp_r;
  logic [25:0] x_mant_r;
  logic [25:0] y_mant_r;

  // Working result. The exponent is 9 bits so that a carry out of 254 is visible.
  logic        res_sign_r;
  logic [8:0]  res_exp_r;
  logic [26:0] res_mant_r;

  // Architectural state.
  logic [31:0]      acc_r;
  logic [CNT_W-1:0] count_r;
  logic             sum_valid_r;
  logic             exc_r;
  logic             ovf_r;
  logic             uf_r;

  // Combinational helpers.
  logic        accept_s;
  logic        ignore_s;
  logic        a_zero_s;
  logic        a_sign_s;
  logic [7:0]  a_exp_s;
  logic [25:0] a_mant_s;
  logic        b_zero_s;
  logic        b_sign_s;
  logic [7:0]  b_exp_s;
  logic [25:0] b_mant_s;
  logic        al_x_sign_s;
  logic        al_y_sign_s;
  logic [7:0]  al_x_exp_s;
  logic [7:0]  al_y_exp_s;
  logic [25:0] al_x_mant_s;
  logic [25:0] al_y_mant_s;
  logic [7:0]  exp_diff_s;
  logic [25:0] y_shift_s;
  logic [26:0] sum_s;
  logic [26:0] add_mant_s;
  logic [8:0]  add_exp_s;
  logic        add_sign_s;
  logic        add_zero_s;
  logic        norm_done_s;
  logic        norm_uf_s;

  assign accept_s = in_valid & in_ready;

  // Products flagged by the multiplier, and everything after a latched overflow,
  // are captured but never reach the adder.
  assign ignore_s = in_exc_r | (in_data_r[30:23] == 8'hFF) | in_ovf_r | ovf_r;

  // Unpack both operands and align the smaller one under the larger one.
  always_comb begin
    a_zero_s = (acc_r[30:23] == 8'd0);
    a_sign_s = a_zero_s ? 1'b0 : acc_r[31];
    a_exp_s  = acc_r[30:23];
    a_mant_s = a_zero_s ? 26'd0 : {1'b1, acc_r[22:0], 2'b00};
    b_zero_s = in_uf_r | (in_data_r[30:23] == 8'd0);
    b_sign_s = b_zero_s ? 1'b0 : in_data_r[31];
    b_exp_s  = b_zero_s ? 8'd0 : in_data_r[30:23];
    b_mant_s = b_zero_s ? 26'd0 : {1'b1, in_data_r[22:0], 2'b00};
    if (b_exp_s > a_exp_s) begin
      al_x_sign_s = b_sign_s;
      al_x_exp_s  = b_exp_s;
      al_x_mant_s = b_mant_s;
      al_y_sign_s = a_sign_s;
      al_y_exp_s  = a_exp_s;
      al_y_mant_s = a_mant_s;
    end else begin
      al_x_sign_s = a_sign_s;
      al_x_exp_s  = a_exp_s;
      al_x_mant_s = a_mant_s;
      al_y_sign_s = b_sign_s;
      al_y_exp_s  = b_exp_s;
      al_y_mant_s = b_mant_s;
    end
    exp_diff_s = al_x_exp_s - al_y_exp_s;
    if (exp_diff_s >= 8'd26) begin
      y_shift_s = 26'd0;
    end else begin
      y_shift_s = al_y_mant_s >> exp_diff_s;
    end
  end

  // Add or subtract the aligned magnitudes. On a carry, renormalise right by one.
  always_comb begin
    sum_s = {1'b0, x_mant_r} + {1'b0, y_mant_r};
    if (x_sign_r == y_sign_r) begin
      add_sign_s = x_sign_r;
      if (sum_s[26]) begin
        add_mant_s = {1'b0, sum_s[26:1]};
        add_exp_s  = {1'b0, x_exp_r} + 9'd1;
      end else begin
        add_mant_s = sum_s;
        add_exp_s  = {1'b0, x_exp_r};
      end
    end else if (x_mant_r >= y_mant_r) begin
      add_sign_s = x_sign_r;
      add_mant_s = {1'b0, x_mant_r - y_mant_r};
      add_exp_s  = {1'b0, x_exp_r};
    end else begin
      add_sign_s = y_sign_r;
      add_mant_s = {1'b0, y_mant_r - x_mant_r};
      add_exp_s  = {1'b0, x_exp_r};
    end
    add_zero_s = (add_mant_s == 27'd0);
  end

  // Normalisation is finished once the leading one sits at bit 25. It is cut
  // short when the next shift would push the exponent down to zero.
  always_comb begin
    norm_done_s = res_mant_r[25];
    norm_uf_s   = ~res_mant_r[25] & (res_exp_r <= 9'd1);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. A clear returns to IDLE from any state.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = accept_s ? ALIGN : IDLE;
        ALIGN:   state_s = ignore_s ? IDLE : ADD;
        ADD:     state_s = add_zero_s ? PACK : NORM;
        NORM:    state_s = (norm_done_s | norm_uf_s) ? PACK : NORM;
        PACK:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Datapath, sum register, counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_data_r   <= 32'd0;
      in_exc_r    <= 1'b0;
      in_ovf_r    <= 1'b0;
      in_uf_r     <= 1'b0;
      x_sign_r    <= 1'b0;
      y_sign_r    <= 1'b0;
      x_exp_r     <= 8'd0;
      x_mant_r    <= 26'd0;
      y_mant_r    <= 26'd0;
      res_sign_r  <= 1'b0;
      res_exp_r   <= 9'd0;
      res_mant_r  <= 27'd0;
      acc_r       <= 32'd0;
      count_r     <= {CNT_W{1'b0}};
      sum_valid_r <= 1'b0;
      exc_r       <= 1'b0;
      ovf_r       <= 1'b0;
      uf_r        <= 1'b0;
    end else if (clear) begin
      acc_r       <= 32'd0;
      count_r     <= {CNT_W{1'b0}};
      sum_valid_r <= 1'b0;
      exc_r       <= 1'b0;
      ovf_r       <= 1'b0;
      uf_r        <= 1'b0;
    end else begin
      sum_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_data_r <= in_data;
            in_exc_r  <= in_exception;
            in_ovf_r  <= in_overflow;
            in_uf_r   <= in_underflow;
          end
        end
        ALIGN: begin
          if (in_exc_r | (in_data_r[30:23] == 8'hFF)) begin
            exc_r <= 1'b1;
          end
          if (in_ovf_r) begin
            ovf_r <= 1'b1;
          end
          if (in_uf_r & ~ignore_s) begin
            uf_r <= 1'b1;
          end
          x_sign_r <= al_x_sign_s;
          y_sign_r <= al_y_sign_s;
          x_exp_r  <= al_x_exp_s;
          x_mant_r <= al_x_mant_s;
          y_mant_r <= y_shift_s;
        end
        ADD: begin
          res_sign_r <= add_zero_s ? 1'b0 : add_sign_s;
          res_exp_r  <= add_zero_s ? 9'd0 : add_exp_s;
          res_mant_r <= add_mant_s;
        end
        NORM: begin
          if (norm_done_s) begin
            res_mant_r <= res_mant_r;
          end else if (norm_uf_s) begin
            res_sign_r <= 1'b0;
            res_exp_r  <= 9'd0;
            res_mant_r <= 27'd0;
            uf_r       <= 1'b1;
          end else begin
            res_mant_r <= {res_mant_r[25:0], 1'b0};
            res_exp_r  <= res_exp_r - 9'd1;
          end
        end
        PACK: begin
          if (res_mant_r == 27'd0) begin
            acc_r <= 32'd0;
          end else if (res_exp_r >= 9'd255) begin
            acc_r <= {res_sign_r, 8'hFF, 23'd0};
            ovf_r <= 1'b1;
          end else begin
            acc_r <= {res_sign_r, res_exp_r[7:0], res_mant_r[24:2]};
          end
          if (count_r != {CNT_W{1'b1}}) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          sum_valid_r <= 1'b1;
        end
        default: begin
          sum_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) & ~clear;
  assign busy      = (state_r != IDLE);
  assign acc_out   = acc_r;
  assign sum_valid = sum_valid_r;
  assign count     = count_r;
  assign exc_flag  = exc_r;
  assign ovf_flag  = ovf_r;
  assign uf_flag   = uf_r;

endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed, table-driven bench for fp_product_accumulator with hand-computed sums.
module tb_fp_product_accumulator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'd0;
  logic             in_exception = 1'b0;
  logic             in_overflow = 1'b0;
  logic             in_underflow = 1'b0;
  logic [31:0]      acc_out;
  logic             sum_valid;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             exc_flag;
  logic             ovf_flag;
  logic             uf_flag;

  int errors = 0;
  int checks = 0;

  fp_product_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .acc_out(acc_out), .sum_valid(sum_valid), .count(count), .busy(busy),
    .exc_flag(exc_flag), .ovf_flag(ovf_flag), .uf_flag(uf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pre_clear;
    logic [31:0] data;
    logic        exc;
    logic        ovf;
    logic        uf;
    logic [31:0] e_acc;
    int          e_cnt;
    logic        e_valid;
    int          e_lat;   // 0: latency not checked
    logic        e_exc;
    logic        e_ovf;
    logic        e_uf;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for in_ready, present one product, return right after the accepting edge.
  task automatic send(input logic [31:0] d, input logic e, input logic o, input logic u);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    in_data      = d;
    in_exception = e;
    in_overflow  = o;
    in_underflow = u;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_exception = 1'b0;
    in_overflow  = 1'b0;
    in_underflow = 1'b0;
  endtask

  // Count edges after the accept until sum_valid, noting whether in_ready rose early.
  task automatic wait_sum(input int max_edges, output int lat, output int rdy_bad);
    lat = 0;
    rdy_bad = 0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (sum_valid) begin
        lat = i;
        break;
      end
      if (in_ready) rdy_bad++;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_acc", acc_out, 32'd0);
    chk("clear_count", {24'd0, count}, 32'd0);
  endtask

  initial begin
    int lat;
    int rdy_bad;
    int pulses;
    string tag;

    //          clr   data          e     o     u     acc           cnt vld   lat E     O     U
    vecs[0]  = '{1'b0, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 1, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0, 32'h40700000, 2, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 1, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h00000000, 2, 1'b1, 0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'hBF7FFFFF, 1'b0, 1'b0, 1'b0, 32'h33800000, 2, 1'b1, 28, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 1, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0, 32'h7F800000, 2, 1'b1, 4,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 2, 1'b0, 0,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h00000000, 0, 1'b0, 0,  1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1, 1'b1, 4,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1, 1'b0, 0,  1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1, 1'b1, 0,  1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 32'h40400000, 2, 1'b1, 4,  1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h00400000, 1'b0, 1'b0, 1'b0, 32'h40400000, 3, 1'b1, 4,  1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 32'h3F800000, 1'b0, 1'b1, 1'b0, 32'h40400000, 3, 1'b0, 0,  1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 32'hC0400000, 1'b0, 1'b0, 1'b0, 32'h40400000, 3, 1'b0, 0,  1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0, 32'h40400000, 1, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0, 32'h40000000, 2, 1'b1, 4,  1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 32'hC0800000, 1'b0, 1'b0, 1'b0, 32'hC0000000, 3, 1'b1, 5,  1'b0, 1'b0, 1'b0};

    // Power-on reset, checked before any clock edge is needed.
    #2;
    reset = 1'b1;
    #1;
    chk("reset_acc", acc_out, 32'd0);
    chk("reset_count", {24'd0, count}, 32'd0);
    chk("reset_ready_busy_valid", {29'd0, in_ready, busy, sum_valid}, 32'h4);
    chk("reset_flags", {29'd0, exc_flag, ovf_flag, uf_flag}, 32'd0);
    #10;
    reset = 1'b0;

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].pre_clear) do_clear();
      send(vecs[v].data, vecs[v].exc, vecs[v].ovf, vecs[v].uf);
      $sformat(tag, "v%0d", v);
      if (vecs[v].e_valid) begin
        wait_sum(60, lat, rdy_bad);
        chk({tag, "_sum_valid_seen"}, {31'd0, (lat != 0)}, 32'd1);
        if (vecs[v].e_lat != 0) chk({tag, "_latency"}, lat, vecs[v].e_lat);
        chk({tag, "_ready_low_while_busy"}, rdy_bad, 32'd0);
        chk({tag, "_ready_at_pulse"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_one_cycle"}, {31'd0, sum_valid}, 32'd0);
      end else begin
        @(posedge clk);
        #1;
        chk({tag, "_idle_at_e1"}, {30'd0, busy, in_ready}, 32'd1);
        wait_sum(10, lat, rdy_bad);
        chk({tag, "_no_sum_valid"}, lat, 32'd0);
      end
      chk({tag, "_acc"}, acc_out, vecs[v].e_acc);
      chk({tag, "_count"}, {24'd0, count}, vecs[v].e_cnt);
      chk({tag, "_flags"}, {29'd0, exc_flag, ovf_flag, uf_flag},
          {29'd0, vecs[v].e_exc, vecs[v].e_ovf, vecs[v].e_uf});
    end

    // Asynchronous reset while busy with sticky flags set.
    do_clear();
    send(32'h40400000, 1'b0, 1'b0, 1'b1);
    wait_sum(60, lat, rdy_bad);
    send(32'h3F800000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_flags", {29'd0, exc_flag, ovf_flag, uf_flag}, 32'h3);
    send(32'h3F800000, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_acc", acc_out, 32'd0);
    chk("midreset_count", {24'd0, count}, 32'd0);
    chk("midreset_ready_busy", {30'd0, in_ready, busy}, 32'h2);
    chk("midreset_flags", {29'd0, exc_flag, ovf_flag, uf_flag}, 32'd0);
    #7;
    reset = 1'b0;

    // Clear during normalisation of a deep-cancellation add.
    send(32'h3F800000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("seq_exc_flag", {31'd0, exc_flag}, 32'd1);
    send(32'h3F800000, 1'b0, 1'b0, 1'b0);
    wait_sum(60, lat, rdy_bad);
    chk("seq_one_acc", acc_out, 32'h3F800000);
    send(32'hBF7FFFFF, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("seq_busy_in_norm", {31'd0, busy}, 32'd1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("norm_clear_busy", {31'd0, busy}, 32'd0);
    chk("norm_clear_acc", acc_out, 32'd0);
    chk("norm_clear_count", {24'd0, count}, 32'd0);
    chk("norm_clear_flags", {29'd0, exc_flag, ovf_flag, uf_flag}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (sum_valid) pulses++;
    end
    chk("norm_clear_no_pulse", pulses, 32'd0);
    chk("norm_clear_acc_after", acc_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
